// File: rtl/id_stage_params.sv
// Shared types and constants for the MIPS decode stage: bus layouts,
// one-hot ALU operation indices and the opcode/funct encodings it decodes.
package id_stage_params;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 12;

  // Bit positions inside the one-hot alu_op vector.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Primary opcodes.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes.
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // jal links into $31.
  localparam logic [REG_ADDR_WIDTH-1:0] RA_REG = 5'd31;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] program_count;
    logic [DATA_WIDTH-1:0] instruction;
  } IFToIDInstructionBusData;

  typedef struct packed {
    logic                  taken;
    logic [DATA_WIDTH-1:0] target;
  } IDToIFBranchBusData;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     pc;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic                      src1_is_sa;
    logic                      src1_is_pc;
    logic                      src2_is_imm;
    logic                      src2_is_zext;
    logic                      src2_is_8;
    logic                      res_from_mem;
    logic                      gr_we;
    logic                      mem_we;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]     rs_value;
    logic [DATA_WIDTH-1:0]     rt_value;
    logic [15:0]               imm;
  } IDToEXEDecodeBusData;

  typedef struct packed {
    logic                      write_enable;
    logic [REG_ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0]     write_data;
  } WBToRFBusData;

  localparam int IF_TO_ID_BUS_WIDTH  = $bits(IFToIDInstructionBusData);
  localparam int ID_TO_IF_BUS_WIDTH  = $bits(IDToIFBranchBusData);
  localparam int ID_TO_EXE_BUS_WIDTH = $bits(IDToEXEDecodeBusData);
  localparam int WB_TO_RF_BUS_WIDTH  = $bits(WBToRFBusData);

  // True when a used, nonzero source register is still owed by EXE, MEM or WB.
  function automatic logic raw_hit(input logic [REG_ADDR_WIDTH-1:0] src,
                                   input logic [REG_ADDR_WIDTH-1:0] exe_d,
                                   input logic [REG_ADDR_WIDTH-1:0] mem_d,
                                   input logic [REG_ADDR_WIDTH-1:0] wb_d);
    return (src != '0) && ((src == exe_d) || (src == mem_d) || (src == wb_d));
  endfunction

endpackage

// File: rtl/regfile.sv
// General-purpose register file: 32 x 32-bit, two combinational read ports,
// one write port committed on the rising clock edge. $0 is hardwired to zero.
module regfile
  import id_stage_params::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0]     rdata1,
  input  logic [REG_ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0]     rdata2,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];

  // Next register contents: only the addressed entry changes, and never $0.
  always_comb begin
    // NOTE: the full default assignment up front means no path leaves rf_d unassigned, so no latch is inferred.
    rf_d = rf_q;
    if (we && (waddr != '0)) begin
      rf_d[waddr] = wdata;
    end
  end

  // Register storage with asynchronous clear of every entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is built from flops, not a RAM macro, which is what allows every entry to be reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      rf_q <= rf_d;
    end
  end

  // Reads return the value before any same-cycle write; $0 reads zero.
  assign rdata1 = (raddr1 == '0) ? '0 : rf_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : rf_q[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode stage of the 5-stage MIPS pipeline: IF->ID latch, instruction
// decoder, RAW interlock (no forwarding), branch unit and register file.
module id_stage
  import id_stage_params::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic [IF_TO_ID_BUS_WIDTH-1:0]  if_to_id_instruction_bus,
  output logic                           id_allow_in,
  output logic [ID_TO_IF_BUS_WIDTH-1:0]  id_to_if_branch_bus,
  input  logic                           exe_allow_in,
  output logic [ID_TO_EXE_BUS_WIDTH-1:0] id_to_exe_decode_bus,
  input  logic [REG_ADDR_WIDTH-1:0]      exe_dest,
  input  logic [REG_ADDR_WIDTH-1:0]      mem_dest,
  input  logic [REG_ADDR_WIDTH-1:0]      wb_dest,
  input  logic [WB_TO_RF_BUS_WIDTH-1:0]  wb_to_rf_bus
);

  IFToIDInstructionBusData if_bus;
  WBToRFBusData            wb_bus;
  IDToIFBranchBusData      br_bus;
  IDToEXEDecodeBusData     dec_bus;

  assign if_bus = if_to_id_instruction_bus;
  assign wb_bus = wb_to_rf_bus;

  // Pipeline latch state.
  logic                  id_valid_q, id_valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  id_ready_go;

  // Instruction fields.
  logic [5:0]                opcode, funct;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic [15:0]               imm;
  logic [25:0]               instr_index;

  assign opcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign funct       = instr_q[5:0];
  assign imm         = instr_q[15:0];
  assign instr_index = instr_q[25:0];

  // Per-instruction decode strobes; anything unmatched falls through as a NOP.
  logic op_special;
  logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or, inst_xor, inst_nor;
  logic inst_sll, inst_srl, inst_sra, inst_jr;
  logic inst_addiu, inst_lui, inst_lw, inst_sw, inst_beq, inst_bne, inst_jal;
  logic inst_r_alu, inst_shift, rs_used, rt_used;

  assign op_special = (opcode == OP_SPECIAL);
  assign inst_addu  = op_special && (funct == FN_ADDU);
  assign inst_subu  = op_special && (funct == FN_SUBU);
  assign inst_slt   = op_special && (funct == FN_SLT);
  assign inst_sltu  = op_special && (funct == FN_SLTU);
  assign inst_and   = op_special && (funct == FN_AND);
  assign inst_or    = op_special && (funct == FN_OR);
  assign inst_xor   = op_special && (funct == FN_XOR);
  assign inst_nor   = op_special && (funct == FN_NOR);
  assign inst_sll   = op_special && (funct == FN_SLL);
  assign inst_srl   = op_special && (funct == FN_SRL);
  assign inst_sra   = op_special && (funct == FN_SRA);
  assign inst_jr    = op_special && (funct == FN_JR);
  assign inst_addiu = (opcode == OP_ADDIU);
  assign inst_lui   = (opcode == OP_LUI);
  assign inst_lw    = (opcode == OP_LW);
  assign inst_sw    = (opcode == OP_SW);
  assign inst_beq   = (opcode == OP_BEQ);
  assign inst_bne   = (opcode == OP_BNE);
  assign inst_jal   = (opcode == OP_JAL);

  assign inst_shift = inst_sll || inst_srl || inst_sra;
  assign inst_r_alu = inst_addu || inst_subu || inst_slt || inst_sltu || inst_and ||
                      inst_or || inst_xor || inst_nor || inst_shift;

  // Shifts take their first operand from sa, so rs is only a real source elsewhere.
  assign rs_used = (inst_r_alu && !inst_shift) || inst_jr || inst_addiu || inst_lw ||
                   inst_sw || inst_beq || inst_bne;
  assign rt_used = inst_r_alu || inst_jr || inst_beq || inst_bne || inst_sw;

  // Operand read.
  logic [DATA_WIDTH-1:0] rs_value, rt_value;

  regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (rs),
    .rdata1 (rs_value),
    .raddr2 (rt),
    .rdata2 (rt_value),
    .we     (wb_bus.write_enable),
    .waddr  (wb_bus.write_address),
    .wdata  (wb_bus.write_data)
  );

  // RAW interlock: hold in ID until no downstream stage still owes a used source.
  assign id_ready_go = !(rs_used && raw_hit(rs, exe_dest, mem_dest, wb_dest)) &&
                       !(rt_used && raw_hit(rt, exe_dest, mem_dest, wb_dest));

  assign id_allow_in = !id_valid_q || (id_ready_go && exe_allow_in);

  // Latch next: accept a new slot when allowed, capture payload only for valid inputs.
  always_comb begin
    id_valid_d = id_valid_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    if (id_allow_in) begin
      id_valid_d = if_bus.valid;
    end
    if (id_allow_in && if_bus.valid) begin
      pc_d    = if_bus.program_count;
      instr_d = if_bus.instruction;
    end
  end

  // IF->ID pipeline register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_valid_q <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  // Branch unit: condition and target resolved from the held operands.
  logic [DATA_WIDTH-1:0] pc_plus4, br_offset;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    br_bus.taken = id_valid_q && id_ready_go &&
                   ((inst_beq && (rs_value == rt_value)) ||
                    (inst_bne && (rs_value != rt_value)) ||
                    inst_jal || inst_jr);
    if (inst_jr) begin
      br_bus.target = rs_value;
    end else if (inst_jal) begin
      br_bus.target = {pc_plus4[31:28], instr_index, 2'b00};
    end else begin
      br_bus.target = pc_plus4 + br_offset;
    end
  end

  // Decode bus to EXE: one-hot ALU op, operand selects and destination.
  always_comb begin
    dec_bus              = '0;
    dec_bus.valid        = id_valid_q && id_ready_go;
    dec_bus.pc           = pc_q;
    dec_bus.alu_op[ALU_ADD]  = inst_addu || inst_addiu || inst_lw || inst_sw || inst_jal;
    dec_bus.alu_op[ALU_SUB]  = inst_subu;
    dec_bus.alu_op[ALU_SLT]  = inst_slt;
    dec_bus.alu_op[ALU_SLTU] = inst_sltu;
    dec_bus.alu_op[ALU_AND]  = inst_and;
    dec_bus.alu_op[ALU_NOR]  = inst_nor;
    dec_bus.alu_op[ALU_OR]   = inst_or;
    dec_bus.alu_op[ALU_XOR]  = inst_xor;
    dec_bus.alu_op[ALU_SLL]  = inst_sll;
    dec_bus.alu_op[ALU_SRL]  = inst_srl;
    dec_bus.alu_op[ALU_SRA]  = inst_sra;
    dec_bus.alu_op[ALU_LUI]  = inst_lui;
    dec_bus.src1_is_sa   = inst_shift;
    dec_bus.src1_is_pc   = inst_jal;
    dec_bus.src2_is_imm  = inst_addiu || inst_lui || inst_lw || inst_sw;
    dec_bus.src2_is_zext = 1'b0;
    dec_bus.src2_is_8    = inst_jal;
    dec_bus.res_from_mem = inst_lw;
    dec_bus.gr_we        = inst_r_alu || inst_addiu || inst_lui || inst_lw || inst_jal;
    dec_bus.mem_we       = inst_sw;
    if (inst_jal) begin
      dec_bus.dest = RA_REG;
    end else if (inst_r_alu) begin
      dec_bus.dest = rd;
    end else if (inst_addiu || inst_lui || inst_lw) begin
      dec_bus.dest = rt;
    end
    dec_bus.rs_value     = rs_value;
    dec_bus.rt_value     = rt_value;
    dec_bus.imm          = imm;
  end

  assign id_to_if_branch_bus  = br_bus;
  assign id_to_exe_decode_bus = dec_bus;

endmodule
